// File: rtl/hdmi_frame_checker.sv
// hdmi_frame_checker: rebuilds active-video X/Y from de/vsync, recomputes the
// test-pattern colour per pixel and reports per-frame error count, first
// failing coordinate, measured geometry and a multi-frame lock flag.
// Three-stage pipeline: coordinates/compare, registered mismatch,
// accumulate; results are published three cycles after each frame start.
module hdmi_frame_checker #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2,
    parameter int ERR_W       = 24,
    parameter bit VSYNC_POL   = 1'b1
) (
    input  logic             pixclk,
    input  logic             reset,
    input  logic             de,
    input  logic             vsync,
    input  logic [7:0]       red,
    input  logic [7:0]       green,
    input  logic [7:0]       blue,
    output logic             frame_done,
    output logic             frame_ok,
    output logic             locked,
    output logic [ERR_W-1:0] error_count,
    output logic [9:0]       first_err_x,
    output logic [9:0]       first_err_y,
    output logic [9:0]       meas_width,
    output logic [9:0]       meas_height
);

    localparam logic [9:0]       COORD_MAX = 10'h3FF;
    localparam logic [9:0]       H_EXP     = 10'(H_ACTIVE);
    localparam logic [9:0]       V_EXP     = 10'(V_ACTIVE);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;
    localparam int               LCNT_W    = $clog2(LOCK_FRAMES + 1);
    localparam logic [LCNT_W-1:0] LOCK_MAX = LCNT_W'(LOCK_FRAMES);

    typedef enum logic {IDLE, CHECK} state_t;

    // Expected test-pattern colour {r,g,b} for the low 8 bits of (x, y).
    function automatic logic [23:0] pattern(input logic [7:0] px, input logic [7:0] py);
        logic [7:0] w;
        logic [7:0] a;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       ramp_en;
        w       = {8{px == py}};
        a       = {8{(px[7:5] == 3'b010) && (py[7:5] == 3'b010)}};
        ramp_en = (py[4:3] == ~px[4:3]);
        r       = ({px[5:0] & {6{ramp_en}}, 2'b00} | w) & ~a;
        g       = ((px & {8{py[6]}}) | w) & ~a;
        b       = py | w | a;
        return {r, g, b};
    endfunction

    state_t state_reg, state_next;
    logic   vs_prev_reg, de_prev_reg;
    logic   vs_act, vs_start, de_fall;
    logic   pix_valid, line_end, publish;

    logic [9:0] x_reg, y_reg, width_reg;
    logic       werr_reg;
    logic [9:0] x_use, y_use, y_inc;
    logic [9:0] fin_width, fin_height;
    logic       fin_werr;

    logic [23:0] exp_rgb, rx_rgb;
    logic [2:0]  chan_mis;

    logic       s1_mis_reg, s1_start_reg, s1_pub_reg, s1_geom_ok_reg;
    logic [9:0] s1_x_reg, s1_y_reg, s1_width_reg, s1_height_reg;

    logic [ERR_W-1:0] err_cnt_reg;
    logic             first_seen_reg;
    logic [9:0]       first_x_reg, first_y_reg;

    logic             res_pub_reg, res_ok_reg;
    logic [ERR_W-1:0] res_err_reg;
    logic [9:0]       res_fx_reg, res_fy_reg, res_width_reg, res_height_reg;

    logic [LCNT_W-1:0] good_cnt_reg;

    assign vs_act   = (vsync == VSYNC_POL);
    assign vs_start = vs_act & ~vs_prev_reg;
    assign de_fall  = de_prev_reg & ~de;

    // Registered copies of the sync-level and de for edge detection.
    always_ff @(posedge pixclk) begin
        if (reset) begin
            vs_prev_reg <= 1'b0;
            de_prev_reg <= 1'b0;
        end else begin
            vs_prev_reg <= vs_act;
            de_prev_reg <= de;
        end
    end

    // State register.
    always_ff @(posedge pixclk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and per-cycle qualifiers; IDLE only reacts to a frame start.
    always_comb begin
        state_next = state_reg;
        pix_valid  = 1'b0;
        line_end   = 1'b0;
        publish    = 1'b0;
        case (state_reg)
            IDLE: begin
                pix_valid = de & vs_start;
                if (vs_start) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                pix_valid = de;
                line_end  = de_fall;
                publish   = vs_start;
            end
            default: state_next = IDLE;
        endcase
    end

    // A pixel coincident with the frame start is (0,0) of the new frame.
    assign x_use = vs_start ? 10'd0 : x_reg;
    assign y_use = vs_start ? 10'd0 : y_reg;
    assign y_inc = (y_reg == COORD_MAX) ? y_reg : y_reg + 10'd1;

    // Geometry as it stands including a line that ends in this very cycle.
    assign fin_width  = line_end ? x_reg : width_reg;
    assign fin_height = line_end ? y_inc : y_reg;
    assign fin_werr   = werr_reg | (line_end & (x_reg != H_EXP));

    // Stage 0 coordinate counters and per-line width tracking.
    always_ff @(posedge pixclk) begin
        if (reset) begin
            x_reg     <= 10'd0;
            y_reg     <= 10'd0;
            width_reg <= 10'd0;
            werr_reg  <= 1'b0;
        end else if (vs_start) begin
            x_reg     <= {9'd0, de};
            y_reg     <= 10'd0;
            width_reg <= 10'd0;
            werr_reg  <= 1'b0;
        end else if (state_reg == CHECK) begin
            if (de && x_reg != COORD_MAX) begin
                x_reg <= x_reg + 10'd1;
            end
            if (line_end) begin
                x_reg     <= 10'd0;
                y_reg     <= y_inc;
                width_reg <= x_reg;
                werr_reg  <= fin_werr;
            end
        end
    end

    assign exp_rgb = pattern(x_use[7:0], y_use[7:0]);
    assign rx_rgb  = {red, green, blue};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            assign chan_mis[gi] = (rx_rgb[gi*8 +: 8] != exp_rgb[gi*8 +: 8]);
        end
    endgenerate

    // Stage 1: registered mismatch plus frame-boundary marker and geometry snapshot.
    always_ff @(posedge pixclk) begin
        if (reset) begin
            s1_mis_reg     <= 1'b0;
            s1_x_reg       <= 10'd0;
            s1_y_reg       <= 10'd0;
            s1_start_reg   <= 1'b0;
            s1_pub_reg     <= 1'b0;
            s1_width_reg   <= 10'd0;
            s1_height_reg  <= 10'd0;
            s1_geom_ok_reg <= 1'b0;
        end else begin
            s1_mis_reg   <= pix_valid & (|chan_mis);
            s1_x_reg     <= x_use;
            s1_y_reg     <= y_use;
            s1_start_reg <= vs_start;
            s1_pub_reg   <= publish;
            if (vs_start) begin
                s1_width_reg   <= fin_width;
                s1_height_reg  <= fin_height;
                s1_geom_ok_reg <= ~fin_werr & (fin_height == V_EXP);
            end
        end
    end

    // Stage 2: error accumulation; a frame boundary snapshots the old frame
    // and restarts the accumulators with the new frame's first pixel.
    always_ff @(posedge pixclk) begin
        if (reset) begin
            err_cnt_reg    <= '0;
            first_seen_reg <= 1'b0;
            first_x_reg    <= 10'd0;
            first_y_reg    <= 10'd0;
            res_pub_reg    <= 1'b0;
            res_ok_reg     <= 1'b0;
            res_err_reg    <= '0;
            res_fx_reg     <= 10'd0;
            res_fy_reg     <= 10'd0;
            res_width_reg  <= 10'd0;
            res_height_reg <= 10'd0;
        end else begin
            res_pub_reg <= s1_start_reg & s1_pub_reg;
            if (s1_start_reg) begin
                res_err_reg    <= err_cnt_reg;
                res_fx_reg     <= first_x_reg;
                res_fy_reg     <= first_y_reg;
                res_width_reg  <= s1_width_reg;
                res_height_reg <= s1_height_reg;
                res_ok_reg     <= (err_cnt_reg == '0) & s1_geom_ok_reg;
                err_cnt_reg    <= s1_mis_reg ? ERR_W'(1) : '0;
                first_seen_reg <= s1_mis_reg;
                first_x_reg    <= s1_mis_reg ? s1_x_reg : 10'd0;
                first_y_reg    <= s1_mis_reg ? s1_y_reg : 10'd0;
            end else if (s1_mis_reg) begin
                if (err_cnt_reg != ERR_MAX) begin
                    err_cnt_reg <= err_cnt_reg + ERR_W'(1);
                end
                if (!first_seen_reg) begin
                    first_seen_reg <= 1'b1;
                    first_x_reg    <= s1_x_reg;
                    first_y_reg    <= s1_y_reg;
                end
            end
        end
    end

    // Stage 3: publish results and update the good-frame run counter.
    always_ff @(posedge pixclk) begin
        if (reset) begin
            frame_done   <= 1'b0;
            frame_ok     <= 1'b0;
            error_count  <= '0;
            first_err_x  <= 10'd0;
            first_err_y  <= 10'd0;
            meas_width   <= 10'd0;
            meas_height  <= 10'd0;
            good_cnt_reg <= '0;
        end else begin
            frame_done <= res_pub_reg;
            if (res_pub_reg) begin
                frame_ok    <= res_ok_reg;
                error_count <= res_err_reg;
                first_err_x <= res_fx_reg;
                first_err_y <= res_fy_reg;
                meas_width  <= res_width_reg;
                meas_height <= res_height_reg;
                if (!res_ok_reg) begin
                    good_cnt_reg <= '0;
                end else if (good_cnt_reg != LOCK_MAX) begin
                    good_cnt_reg <= good_cnt_reg + LCNT_W'(1);
                end
            end
        end
    end

    assign locked = (good_cnt_reg == LOCK_MAX);

endmodule

// File: tb/tb_hdmi_frame_checker.sv
// Randomized frame-level bench for hdmi_frame_checker. Frames are described
// by line widths plus a corruption list; the expected per-frame report is
// derived directly from those descriptions and the colour rule.
module tb_hdmi_frame_checker;

    localparam int H       = 32;
    localparam int V       = 16;
    localparam int LOCK    = 2;
    localparam int EW      = 4;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          pixclk = 1'b0;
    logic          reset, de, vsync;
    logic [7:0]    red, green, blue;
    logic          frame_done, frame_ok, locked;
    logic [EW-1:0] error_count;
    logic [9:0]    first_err_x, first_err_y, meas_width, meas_height;

    hdmi_frame_checker #(
        .H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(LOCK), .ERR_W(EW), .VSYNC_POL(1'b1)
    ) dut (
        .pixclk(pixclk), .reset(reset), .de(de), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .frame_done(frame_done), .frame_ok(frame_ok), .locked(locked),
        .error_count(error_count), .first_err_x(first_err_x), .first_err_y(first_err_y),
        .meas_width(meas_width), .meas_height(meas_height)
    );

    always #5 pixclk = ~pixclk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_frames = 0;

    // Frame description.
    int          lw[1024];
    int          nl;
    int          cx[$];
    int          cy[$];
    logic [23:0] cm[$];
    bit          all_wrong;
    int          rand_div;
    int          abort_line = -1;
    int          sx[3] = '{5, 80, 3};
    int          sy[3] = '{5, 80, 64};

    // Model of the frame in progress and of the report awaiting publication.
    bit m_inchk, m_seen, m_geom;
    int m_err, m_fx, m_fy, m_width, m_height, lk;
    bit pend_valid, pend_ok, pend_locked;
    int pend_cyc, pend_err, pend_fx, pend_fy, pend_w, pend_h;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Colour rule in plain integer arithmetic.
    function automatic logic [23:0] pat(input int x, input int y);
        int  xl, yl, r, g, b;
        bit  w, a, ramp;
        xl   = x % 256;
        yl   = y % 256;
        w    = (xl == yl);
        a    = ((xl / 32) == 2) && ((yl / 32) == 2);
        // ~x[4:3] is a 2-bit inversion, i.e. 3 - x[4:3]
        ramp = ((yl / 8) % 4) == (3 - (xl / 8) % 4);
        r    = ramp ? (x % 64) * 4 : 0;
        g    = ((yl / 64) % 2 == 1) ? xl : 0;
        b    = yl;
        if (w) begin r = 255; g = 255; b = 255; end
        if (a) begin r = 0; g = 0; b = 255; end
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    // Pixel value sent before corruption; spot coordinates use literal colours.
    // At (3,64) y[4:3]=00 differs from ~x[4:3]=11, so the red ramp is off.
    function automatic logic [23:0] base_rgb(input int x, input int y);
        if (x == 5 && y == 5)   return 24'hFFFFFF;
        if (x == 80 && y == 80) return 24'h0000FF;
        if (x == 3 && y == 64)  return 24'h000340;
        return pat(x, y);
    endfunction

    function automatic logic [23:0] corrupt(input int x, input int y);
        logic [23:0] v;
        v = all_wrong ? 24'hFFFFFF : 24'h0;
        foreach (cx[i]) if (cx[i] == x && cy[i] == y) v ^= cm[i];
        if (rand_div > 0 && $urandom_range(0, rand_div - 1) == 0)
            v ^= 24'd1 << $urandom_range(0, 23);
        return v;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_done"}, int'(frame_done), 0);
        check({tag, "_ok"}, int'(frame_ok), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_errcnt"}, int'(error_count), 0);
        check({tag, "_fx"}, int'(first_err_x), 0);
        check({tag, "_fy"}, int'(first_err_y), 0);
        check({tag, "_width"}, int'(meas_width), 0);
        check({tag, "_height"}, int'(meas_height), 0);
    endtask

    // One clock; outputs sampled 1 time unit after the edge and matched
    // against the pending frame report.
    task automatic tick();
        @(posedge pixclk);
        #1;
        cyc++;
        if (frame_done) begin
            if (!pend_valid) begin
                check("spurious_done", int'(frame_done), 0);
            end else begin
                n_frames++;
                $display("frame %0d: ok=%0d err=%0d first=(%0d,%0d) geom=%0dx%0d locked=%0d",
                         n_frames, frame_ok, error_count, first_err_x, first_err_y,
                         meas_width, meas_height, locked);
                check("done_latency", cyc - pend_cyc, 3);
                check("frame_ok", int'(frame_ok), int'(pend_ok));
                check("error_count", int'(error_count), pend_err);
                check("first_err_x", int'(first_err_x), pend_fx);
                check("first_err_y", int'(first_err_y), pend_fy);
                check("meas_width", int'(meas_width), pend_w);
                check("meas_height", int'(meas_height), pend_h);
                check("locked", int'(locked), int'(pend_locked));
                pend_valid = 0;
            end
        end else if (pend_valid && cyc - pend_cyc >= 3) begin
            check("frame_done", int'(frame_done), 1);
            pend_valid = 0;
        end
    endtask

    task automatic set_clean();
        nl = V;
        foreach (lw[i]) lw[i] = H;
        cx.delete(); cy.delete(); cm.delete();
        all_wrong = 0;
        rand_div  = 0;
    endtask

    // Sparse frame reaching one spot coordinate; optionally flip one bit there.
    task automatic set_spot(input int s, input bit flip);
        set_clean();
        nl = 81;
        foreach (lw[i]) lw[i] = 1;
        lw[5]  = 6;
        lw[64] = 4;
        lw[80] = 81;
        if (flip) begin
            cx.push_back(sx[s]);
            cy.push_back(sy[s]);
            cm.push_back(24'd1 << $urandom_range(0, 23));
        end
    endtask

    task automatic send_frame();
        logic [23:0] v;
        // frame start: hand the finished frame's report to the checker
        vsync = 1'b1;
        if (m_inchk) begin
            pend_ok     = (m_err == 0) && m_geom;
            lk          = pend_ok ? ((lk < LOCK) ? lk + 1 : LOCK) : 0;
            pend_locked = (lk == LOCK);
            pend_err    = m_err;
            pend_fx     = m_fx;
            pend_fy     = m_fy;
            pend_w      = m_width;
            pend_h      = m_height;
            pend_cyc    = cyc;
            pend_valid  = 1;
        end
        m_inchk = 1;
        m_err = 0; m_seen = 0; m_fx = 0; m_fy = 0;
        tick(); tick();
        vsync = 1'b0;
        repeat (4) tick();
        for (int y = 0; y < nl; y++) begin
            if (y == abort_line) begin
                reset = 1'b1;
                tick();
                check_zero("midreset");
                reset = 1'b0;
                m_inchk = 0;
                pend_valid = 0;
                lk = 0;
            end
            for (int x = 0; x < lw[y]; x++) begin
                v = base_rgb(x, y) ^ corrupt(x, y);
                {red, green, blue} = v;
                de = 1'b1;
                if (v != pat(x, y)) begin
                    if (m_err < ERR_MAX) m_err++;
                    if (!m_seen) begin m_seen = 1; m_fx = x; m_fy = y; end
                end
                tick();
            end
            de = 1'b0;
            {red, green, blue} = 24'h0;
            repeat (3) tick();
        end
        repeat (3) tick();
        m_height = nl;
        m_width  = (nl > 0) ? lw[nl - 1] : 0;
        m_geom   = (nl == V);
        for (int y = 0; y < nl; y++) if (lw[y] != H) m_geom = 0;
    endtask

    initial begin
        reset = 1'b1; de = 1'b0; vsync = 1'b0;
        red = 8'h0; green = 8'h0; blue = 8'h0;
        m_inchk = 0; pend_valid = 0; lk = 0;
        m_err = 0; m_seen = 0; m_fx = 0; m_fy = 0; m_width = 0; m_height = 0; m_geom = 0;
        repeat (3) tick();
        check_zero("reset");
        reset = 1'b0;
        tick();

        // clean frames: lock after the second published frame
        set_clean();
        repeat (3) send_frame();

        // two corruptions, the earlier one in raster order is reported
        set_clean();
        cx.push_back($urandom_range(0, H - 1)); cy.push_back($urandom_range(0, V / 2 - 1));
        cm.push_back(24'h010000);
        cx.push_back($urandom_range(0, H - 1)); cy.push_back($urandom_range(V / 2, V - 1));
        cm.push_back(24'h000000 | (24'd1 << $urandom_range(0, 7)));
        send_frame();

        // pattern spot checks: clean, then one bit flipped at each spot
        set_spot(0, 0);
        send_frame();
        for (int s = 0; s < 3; s++) begin
            set_spot(s, 1);
            send_frame();
        end

        // geometry faults
        set_clean(); lw[10] = H - 1; send_frame();
        set_clean(); nl = V - 1;     send_frame();

        // relock, then randomized frames
        set_clean(); repeat (2) send_frame();
        for (int f = 0; f < 6; f++) begin
            set_clean();
            rand_div = $urandom_range(40, 400);
            if ($urandom_range(0, 2) == 0)
                lw[$urandom_range(0, V - 1)] += ($urandom_range(0, 1) == 1) ? 1 : -1;
            if ($urandom_range(0, 3) == 0)
                nl = V + (($urandom_range(0, 1) == 1) ? 1 : -1);
            send_frame();
        end

        // every pixel wrong: counter saturates
        set_clean(); all_wrong = 1; send_frame();

        // back-to-back frame starts with no active lines
        set_clean(); nl = 0; send_frame(); send_frame();

        // reset in the middle of a frame, then two frame starts before a publish
        set_clean(); repeat (3) send_frame();
        abort_line = V / 2; send_frame(); abort_line = -1;
        set_clean(); repeat (3) send_frame();

        // flush the last frame's report
        set_clean(); nl = 0; send_frame();
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
